addrc_slice_server: RTL and testbench
=====================================

// Module: addrc_slice_server
// PURPOSE
// - Memory-side partner of the addRC_Top round engine. Serves slice lines on demand and captures the lines the engine writes.
// - Host side: loads 64 x 25-bit slices over valid/ready, kicks the engine, waits for completion, then streams the 64 results back.
// - Replaces the bench-only memory model; sits between the slice I/O stream and the engine.
// PARAMETERS
// - W      25  slice line width (5x5 bits)
// - DEPTH  64  lines per state (lane length)
// - AW     6   address width, log2(DEPTH)
// PORTS
// - clk            in   1   single clock, rising edge
// - rst            in   1   reset, asynchronous, active-high
// - load_valid     in   1   host load line valid
// - load_ready     out  1   high in S_LOAD
// - load_data      in   W   host load line
// - addrc_en       out  1   engine start, level
// - donee          in   1   engine done, level
// - cnt_value      in   AW  engine read address
// - line_in        out  W   engine read data, combinational
// - write_enable   in   1   engine write strobe
// - write_value    in   W   engine write data
// - out_valid      out  1   result line valid
// - out_ready      in   1   host accepts result line
// - out_data       out  W   result line, registered
// - busy           out  1   state != S_LOAD
// BEHAVIOUR
// - Reset (async): state=S_LOAD; all outputs 0 except load_ready=1. ld_ptr, wr_ptr and rd_ptr=0. Bank contents are not reset.
// - S_LOAD: each cycle with load_valid&load_ready writes in_bank[ld_ptr] and increments ld_ptr.
//   - On acceptance of line 63, go to S_RUN next cycle. ld_ptr wraps to 0.
// - S_RUN: addrc_en=1 registered, high from the first S_RUN cycle.
//   - line_in = in_bank[cnt_value] combinationally, valid in every state.
//   - write_enable=1 sampled each cycle -> out_bank[wr_ptr]=write_value, wr_ptr++ mod 64. Writes are sequential and carry no address.
//   - write_enable outside S_RUN is ignored.
//   - donee rising edge (donee & !donee_q) -> addrc_en=0 next cycle; go to S_DRAIN.
//   - A write in the same cycle as the donee edge is still captured.
// - S_DRAIN: one cycle. Preload out_data=out_bank[0], rd_ptr=1, out_valid=1; go to S_UNLOAD.
// - S_UNLOAD: out_data stays stable while out_valid&!out_ready.
//   - On handshake, load out_bank[rd_ptr] and rd_ptr++.
//   - After the handshake of line 63: out_valid=0, wr_ptr=0, go to S_LOAD. No idle cycle.
// - Latency: load line 63 accepted -> addrc_en high 1 clk later.
// - Latency: donee edge -> out_valid 2 clks later.
// - A donee edge with wr_ptr != 0 (short or long run) still completes and unloads out_bank as-is.
// - Reset mid-operation: addrc_en drops immediately (async); the partially loaded or captured data is discarded.
// CONFIGURATION
// - Macro ADDRC_SRV_CHECK_EN.
// - Defined: adds output err[1:0], sticky until reset, 0 at reset.
//   - err[0] = overrun: a 65th write_enable in one S_RUN.
//   - err[1] = short: donee edge with fewer than 64 writes captured.
// - Not defined: no err port; wrap and short runs are silently tolerated as above.
// STRUCTURE
// - Shared package addrc_pkg: W, DEPTH, AW constants; state encoding S_LOAD=0, S_RUN=1, S_DRAIN=2, S_UNLOAD=3.
// - Sub-module slice_bank: DEPTH x W array, sync write, combinational read.
//   - Instantiated twice: in_bank and out_bank.
// - Top level: FSM, pointers, donee edge detect, output register.
// TESTING
// - Load lines i=0..63 with data i, pair with the real addRC_Top. Per-line results must match the golden model.
//   - out lines emerge in order 0..63; total count 64.
// - Backpressure: out_ready toggles 1,0,0,1 during unload -> out_data is stable while stalled; no line lost or duplicated.
// - Engine stub writes 0x1ABCDEF..+63, with donee on the same cycle as the last write -> all 64 are captured; out_valid 2 clks after the edge.
// - Stub issues 65 writes -> out line 0 holds write #65; with ADDRC_SRV_CHECK_EN, err=2'b01.
// - Stub issues 10 writes then donee -> unload still emits 64 lines; with the macro, err=2'b10.
// - Assert rst while in S_RUN at line 20 -> addrc_en=0 the same cycle.
//   - Then load_ready=1, busy=0; a fresh 64-line load runs correctly.

Source files
------------

// File: rtl/addrc_pkg.sv
// Shared constants and state encoding for the addRC slice server.
package addrc_pkg;
  localparam int W     = 25;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction
endpackage

// File: rtl/addrc_slice_server_slice_bank.sv
// One slice line store: synchronous write, combinational read, contents never reset.
module slice_bank
  import addrc_pkg::*;
#(
  parameter int BW     = W,
  parameter int BDEPTH = DEPTH,
  parameter int BAW    = AW
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [BAW-1:0] waddr_i,
  input  logic [BW-1:0]  wdata_i,
  input  logic [BAW-1:0] raddr_i,
  output logic [BW-1:0]  rdata_o
);
  logic [BW-1:0] mem_q [BDEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/addrc_slice_server.sv
// Memory-side partner of the addRC round engine: load, run, drain, unload.
// Optional macro ADDRC_SRV_CHECK_EN adds a sticky err[1:0] (overrun, short run).
module addrc_slice_server
  import addrc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  output logic          addrc_en,
  input  logic          donee,
  input  logic [AW-1:0] cnt_value,
  output logic [W-1:0]  line_in,
  input  logic          write_enable,
  input  logic [W-1:0]  write_value,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy
`ifdef ADDRC_SRV_CHECK_EN
  ,
  output logic [1:0]    err
`endif
);
  state_t        state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          donee_q;
  logic          addrc_en_q, addrc_en_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;

  logic          load_fire, donee_rise, cap_we, unload_fire;
  logic [AW-1:0] out_raddr;
  logic [W-1:0]  out_rdata;

  assign load_ready  = (state_q == S_LOAD);
  assign busy        = (state_q != S_LOAD);
  assign load_fire   = load_valid & load_ready;
  assign donee_rise  = donee & ~donee_q;
  assign cap_we      = write_enable & (state_q == S_RUN);
  assign unload_fire = out_ready & out_valid_q;
  assign out_raddr   = (state_q == S_DRAIN) ? '0 : rd_ptr_q;

  slice_bank u_in_bank (
    .clk     (clk),
    .we_i    (load_fire),
    .waddr_i (ld_ptr_q),
    .wdata_i (load_data),
    .raddr_i (cnt_value),
    .rdata_o (line_in)
  );

  slice_bank u_out_bank (
    .clk     (clk),
    .we_i    (cap_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (write_value),
    .raddr_i (out_raddr),
    .rdata_o (out_rdata)
  );

  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    addrc_en_d  = addrc_en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_LOAD: begin
        if (load_fire) begin
          ld_ptr_d = ptr_inc(ld_ptr_q);
          if (ld_ptr_q == AW'(DEPTH - 1)) begin
            state_d    = S_RUN;
            addrc_en_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cap_we) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (donee_rise) begin
          addrc_en_d = 1'b0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        out_data_d  = out_rdata;
        rd_ptr_d    = AW'(1);
        out_valid_d = 1'b1;
        state_d     = S_UNLOAD;
      end
      S_UNLOAD: begin
        // rd_ptr has wrapped back to 0 exactly while line 63 is on display
        if (unload_fire) begin
          if (rd_ptr_q == '0) begin
            out_valid_d = 1'b0;
            wr_ptr_d    = '0;
            state_d     = S_LOAD;
          end else begin
            out_data_d = out_rdata;
            rd_ptr_d   = ptr_inc(rd_ptr_q);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      ld_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      donee_q     <= 1'b0;
      addrc_en_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      donee_q     <= donee;
      addrc_en_q  <= addrc_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign addrc_en  = addrc_en_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef ADDRC_SRV_CHECK_EN
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW:0] wr_cnt_q, wr_cnt_d;
  logic [AW:0] captured;
  logic [1:0]  err_q, err_d;

  // Saturating count of captures this run; the donee-cycle write counts too
  assign captured = wr_cnt_q + {{AW{1'b0}}, cap_we};

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    if (state_q == S_LOAD) wr_cnt_d = '0;
    if (cap_we) begin
      if (wr_cnt_q == FULL) err_d[0] = 1'b1;
      else                  wr_cnt_d = wr_cnt_q + (AW + 1)'(1);
    end
    if ((state_q == S_RUN) && donee_rise && (captured < FULL)) err_d[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      err_q    <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;
`endif
endmodule

// File: tb/tb_addrc_slice_server.sv
// Directed-random bench for addrc_slice_server against an array model of both banks.
module tb_addrc_slice_server;
  logic        clk = 1'b0;
  logic        rst, load_valid, donee, write_enable, out_ready;
  logic [24:0] load_data, write_value;
  logic [5:0]  cnt_value;
  logic        load_ready, addrc_en, out_valid, busy;
  logic [24:0] line_in, out_data;
`ifdef ADDRC_SRV_CHECK_EN
  logic [1:0]  err;
  logic [1:0]  exp_err;
`endif

  logic [24:0] in_mem  [64];
  logic [24:0] out_mem [64];
  bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  addrc_slice_server dut (
    .clk          (clk),
    .rst          (rst),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .addrc_en     (addrc_en),
    .donee        (donee),
    .cnt_value    (cnt_value),
    .line_in      (line_in),
    .write_enable (write_enable),
    .write_value  (write_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy)
`ifdef ADDRC_SRV_CHECK_EN
    ,
    .err          (err)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic do_load();
    int  idx   = 0;
    int  guard = 0;
    bit  acc;
    while (idx < 64 && guard < 2000) begin
      load_valid   = ($urandom_range(0, 3) != 0);
      load_data    = in_mem[idx];
      write_enable = $urandom_range(0, 1);
      write_value  = 25'($urandom);
      acc = load_valid && load_ready;
      if (idx == 63 && acc) chk("en_before_last", {31'b0, addrc_en}, 0);
      tick();
      if (acc) idx++;
      guard++;
    end
    load_valid   = 1'b0;
    write_enable = 1'b0;
    chk("load_count", idx, 64);
    chk("en_latency", {31'b0, addrc_en}, 1);
    chk("busy_run", {31'b0, busy}, 1);
    chk("ready_run", {31'b0, load_ready}, 0);
  endtask

  // nw writes; seq selects 0x1ABCDEF+k values; no_done leaves the engine running
  task automatic do_run(input int nw, input bit seq, input bit donee_last, input bit no_done);
    int k = 0;
    while (k < nw) begin
      if ($urandom_range(0, 4) == 0) begin
        write_enable = 1'b0;
        donee        = 1'b0;
      end else begin
        write_enable = 1'b1;
        write_value  = seq ? 25'(32'h1ABCDEF + k) : 25'($urandom);
        donee        = donee_last && (k == nw - 1);
        out_mem[k % 64] = write_value;
        k++;
      end
      cnt_value = 6'($urandom);
      #1;
      chk("line_in_run", line_in, in_mem[cnt_value]);
      tick();
    end
    write_enable = 1'b0;
    if (no_done) return;
    if (!donee_last) begin
      donee = 1'b1;
      tick();
    end
    donee        = 1'b0;
    write_enable = 1'b1;
    write_value  = 25'($urandom);
    chk("en_drop", {31'b0, addrc_en}, 0);
    chk("ov_early", {31'b0, out_valid}, 0);
    tick();
    chk("ov_latency", {31'b0, out_valid}, 1);
`ifdef ADDRC_SRV_CHECK_EN
    if (nw > 64) exp_err[0] = 1'b1;
    if (nw < 64) exp_err[1] = 1'b1;
    chk("err", {30'b0, err}, {30'b0, exp_err});
`endif
  endtask

  task automatic do_unload(input bit use_pat);
    int line = 0;
    int g    = 0;
    bit hs;
    while (line < 64 && g < 1000) begin
      chk("ov_unload", {31'b0, out_valid}, 1);
      chk($sformatf("out_line%0d", line), out_data, out_mem[line]);
      out_ready    = use_pat ? pat[g % 4] : 1'($urandom_range(0, 1));
      write_enable = $urandom_range(0, 1);
      write_value  = 25'($urandom);
      cnt_value    = 6'($urandom);
      #1;
      chk("line_in_unload", line_in, in_mem[cnt_value]);
      hs = out_ready && out_valid;
      tick();
      if (hs) line++;
      g++;
    end
    out_ready    = 1'b0;
    write_enable = 1'b0;
    chk("unload_count", line, 64);
    chk("ov_done", {31'b0, out_valid}, 0);
    chk("ready_done", {31'b0, load_ready}, 1);
    chk("busy_done", {31'b0, busy}, 0);
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; donee = 1'b0; write_enable = 1'b0; out_ready = 1'b0;
    load_data = '0; write_value = '0; cnt_value = '0;
`ifdef ADDRC_SRV_CHECK_EN
    exp_err = 2'b00;
`endif
    #12;
    chk("rst_load_ready", {31'b0, load_ready}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_en", {31'b0, addrc_en}, 0);
    chk("rst_ov", {31'b0, out_valid}, 0);
    chk("rst_od", out_data, 0);
`ifdef ADDRC_SRV_CHECK_EN
    chk("rst_err", {30'b0, err}, 0);
`endif
    tick();
    rst = 1'b0;

    for (int i = 0; i < 64; i++) in_mem[i] = 25'(i);
    do_load();
    do_run(64, 1'b0, 1'b0, 1'b0);
    do_unload(1'b0);
    $display("run A: identity load, 64 random writes, random backpressure done");

    for (int i = 0; i < 64; i++) in_mem[i] = 25'($urandom);
    do_load();
    do_run(64, 1'b1, 1'b1, 1'b0);
    do_unload(1'b1);
    $display("run B: sequential writes, donee on last write, 1-0-0-1 backpressure done");

    for (int i = 0; i < 64; i++) in_mem[i] = 25'($urandom);
    do_load();
    do_run(65, 1'b0, 1'b0, 1'b0);
    do_unload(1'b0);
    $display("run C: 65 writes, line 0 holds write 65 done");

    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef ADDRC_SRV_CHECK_EN
    exp_err = 2'b00;
    chk("err_cleared", {30'b0, err}, 0);
`endif

    for (int i = 0; i < 64; i++) in_mem[i] = 25'($urandom);
    do_load();
    do_run(10, 1'b0, 1'b0, 1'b0);
    do_unload(1'b0);
    $display("run D: short run of 10 writes done");

    for (int i = 0; i < 64; i++) in_mem[i] = 25'($urandom);
    do_load();
    do_run(20, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_en", {31'b0, addrc_en}, 0);
    chk("midrst_ready", {31'b0, load_ready}, 1);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_ov", {31'b0, out_valid}, 0);
    tick();
    rst = 1'b0;
`ifdef ADDRC_SRV_CHECK_EN
    exp_err = 2'b00;
`endif
    $display("run E: reset asserted after 20 writes done");

    for (int i = 0; i < 64; i++) in_mem[i] = 25'($urandom);
    do_load();
    do_run(64, 1'b0, 1'b1, 1'b0);
    do_unload(1'b0);
    $display("run F: fresh full run after mid-run reset done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
